// File: rtl/spi_slave.sv
// SPI slave with 2-flop input synchronizers, a one-word response buffer and a
// configurable frame length; CPOL/CPHA and bit count are latched at frame start.
module spi_slave #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SPI4wire_SCK,
  input  logic              SPI4wire_CS_N,
  input  logic              SPI4wire_MOSI,
  output logic              SPI4wire_MISO,
  input  logic [7:0]        par_adr_sclknum,
  input  logic [7:0]        par_dat_sclknum,
  input  logic              par_cpol,
  input  logic              par_cpha,
  input  logic              tx_tvalid,
  input  logic [DATA_W-1:0] tx_tdata,
  output logic              tx_tready,
  output logic              rx_tvalid,
  output logic [DATA_W-1:0] rx_tdata,
  output logic              rx_err
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t              state_q, state_d;
  logic                sck_p0, sck_p1, sck_p2;
  logic                cs_p0, cs_p1, cs_p2;
  logic                mosi_p0, mosi_p1, mosi_p2;
  logic                cs_fall, cs_rise, sck_rise, sck_fall;
  logic                lead, trail, sample_edge, shift_edge;
  logic                start, finish, accept;
  logic                buf_full_q, buf_full_d;
  logic [DATA_W-1:0]   buf_data_q;
  logic                armed_q;
  logic [1:0]          prime_q;
  logic                cpol_q, cpha_q, first_done_q;
  logic [7:0]          sclk_num_q, sclk_num;
  logic [5:0]          bit_cnt;
  logic [DATA_W-1:0]   tx_sr, rx_sr;

  // Stage p0..p2: synchronizers, p2 is the previous value for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {cs_p0, cs_p1, cs_p2}       <= 3'b111;
      {sck_p0, sck_p1, sck_p2}    <= 3'b000;
      {mosi_p0, mosi_p1, mosi_p2} <= 3'b000;
    end else begin
      cs_p0   <= SPI4wire_CS_N;
      cs_p1   <= cs_p0;
      cs_p2   <= cs_p1;
      sck_p0  <= SPI4wire_SCK;
      sck_p1  <= sck_p0;
      sck_p2  <= sck_p1;
      mosi_p0 <= SPI4wire_MOSI;
      mosi_p1 <= mosi_p0;
      mosi_p2 <= mosi_p1;
    end
  end

  assign cs_fall     = cs_p2 & ~cs_p1;
  assign cs_rise     = ~cs_p2 & cs_p1;
  assign sck_rise    = sck_p1 & ~sck_p2;
  assign sck_fall    = ~sck_p1 & sck_p2;
  assign lead        = cpol_q ? sck_fall : sck_rise;
  assign trail       = cpol_q ? sck_rise : sck_fall;
  // With CPHA=1 the first leading edge only announces bit 31, so it must not shift
  assign sample_edge = (state_q == ACTIVE) & (cpha_q ? trail : lead);
  assign shift_edge  = (state_q == ACTIVE) & (cpha_q ? (lead & first_done_q) : trail);
  assign accept      = tx_tvalid & tx_tready;
  assign sclk_num    = par_adr_sclknum + par_dat_sclknum;
  assign SPI4wire_MISO = tx_sr[DATA_W-1];

  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    finish     = 1'b0;
    unique case (state_q)
      IDLE:    if (cs_fall && armed_q) begin
                 state_d = ACTIVE;
                 start   = 1'b1;
               end
      ACTIVE:  if (cs_rise) begin
                 state_d = DONE;
                 finish  = 1'b1;
               end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // An accept coinciding with frame start keeps the new word for the next frame
    buf_full_d = accept ? 1'b1 : (start ? 1'b0 : buf_full_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      buf_full_q   <= 1'b0;
      tx_tready    <= 1'b0;
      armed_q      <= 1'b0;
      prime_q      <= 2'd0;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      first_done_q <= 1'b0;
      sclk_num_q   <= 8'd0;
      bit_cnt      <= 6'd0;
      tx_sr        <= '0;
      rx_tvalid    <= 1'b0;
      rx_err       <= 1'b0;
      rx_tdata     <= '0;
    end else begin
      state_q    <= state_d;
      buf_full_q <= buf_full_d;
      tx_tready  <= (state_d == IDLE) && !buf_full_d;
      // Synchronizer reset values are not real observations; arm only on pin data
      if (prime_q != 2'd2) prime_q <= prime_q + 2'd1;
      if (prime_q == 2'd2 && cs_p1) armed_q <= 1'b1;
      rx_tvalid <= 1'b0;
      rx_err    <= 1'b0;
      if (start) begin
        cpol_q       <= par_cpol;
        cpha_q       <= par_cpha;
        sclk_num_q   <= sclk_num;
        tx_sr        <= buf_full_q ? buf_data_q : '0;
        bit_cnt      <= 6'd0;
        first_done_q <= 1'b0;
      end else begin
        if (sample_edge && bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
        if (shift_edge) tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
        if (state_q == ACTIVE && lead) first_done_q <= 1'b1;
      end
      if (finish) begin
        if ({2'b00, bit_cnt} == sclk_num_q) begin
          rx_tvalid <= 1'b1;
          rx_tdata  <= rx_sr;
        end else begin
          rx_err <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) buf_data_q <= tx_tdata;
    if (start) rx_sr <= '0;
    else if (sample_edge) rx_sr <= {rx_sr[DATA_W-2:0], mosi_p2};
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Ports SHALL be as follows:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- SPI4wire_SCK  in  1  SPI clock from the master; asynchronous to clk.
- SPI4wire_CS_N  in  1  chip select, active low; asynchronous.
- SPI4wire_MOSI  in  1  master-out data; asynchronous.
- SPI4wire_MISO  out  1  slave-out data; equals tx shift register bit 31.
- par_adr_sclknum  in  8  address-phase SCK count.
- par_dat_sclknum  in  8  data-phase SCK count.
- par_cpol  in  1  SCK idle level.
- par_cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
- tx_tvalid  in  1  response word valid.
- tx_tdata  in  32  response word; bit 31 is sent first.
- tx_tready  out  1  response buffer can accept a word.
- rx_tvalid  out  1  one-cycle pulse: a complete frame was received.
- rx_tdata  out  32  received frame, LSB-aligned; the last bit received is in bit 0.
- rx_err  out  1  one-cycle pulse: the frame ended with the wrong bit count.

Function
REQ-003 SCK, CS_N and MOSI SHALL each pass through a 2-flop synchronizer, followed by a third flop used for edge detection.
REQ-004 SCLK_NUM SHALL be par_adr_sclknum + par_dat_sclknum, computed 8-bit; legal range is 1..32. Other values are undefined.
REQ-005 par_* inputs SHALL be captured in the cycle CS_N falls, and held constant for the rest of the frame.
REQ-006 Leading edge SHALL mean the SCK transition away from par_cpol; trailing edge is the return to par_cpol.
REQ-007 States SHALL be IDLE, ACTIVE and DONE:
- IDLE -> ACTIVE on a synchronized CS_N falling edge while armed.
- ACTIVE -> DONE on a synchronized CS_N rising edge.
- DONE -> IDLE after exactly one cycle.
REQ-008 The block SHALL become armed only after synchronized CS_N has been seen high for at least one cycle after reset. A CS_N that is already low at reset release starts no frame.
REQ-009 Response buffer: tx_tready SHALL be 1 only in IDLE with the buffer empty.
- A word is accepted when tx_tvalid && tx_tready.
- The buffer is then full and tx_tready goes low the next cycle.
REQ-010 On IDLE->ACTIVE, the tx shift register SHALL load the buffer word if the buffer is full (buffer becomes empty), or 32'd0 if it is empty.
REQ-011 If an accept and the CS_N fall occur in the same cycle, the frame SHALL send 32'd0 and the accepted word SHALL stay buffered for the next frame.
REQ-012 Sample edge (leading if cpha=0, trailing if cpha=1), in ACTIVE:
- The rx shift register SHALL shift left with MOSI entering bit 0.
- bit_cnt SHALL increment, saturating at 63.
REQ-013 Shift edge (trailing if cpha=0, leading if cpha=1), in ACTIVE: the tx shift register SHALL shift left and fill with 0. Exception: with cpha=1 the first leading edge of a frame does not shift.
REQ-014 MISO SHALL change no more than 4 clk cycles after the SCK shift edge at the pin. Therefore clk SHALL be at least 8x the SCK frequency.
REQ-015 On ACTIVE->DONE with bit_cnt == SCLK_NUM:
- rx_tvalid SHALL pulse for 1 cycle, in DONE.
- rx_tdata SHALL take the rx shift register value.
- Bits above SCLK_NUM-1 are zero.
REQ-016 On ACTIVE->DONE with bit_cnt != SCLK_NUM: rx_err SHALL pulse for 1 cycle, rx_tvalid stays 0, and rx_tdata holds its previous value.
REQ-017 The rx shift register and bit_cnt SHALL clear on IDLE->ACTIVE.
REQ-018 SCK edges seen while not ACTIVE SHALL be ignored.

Reset
REQ-019 While rst_n=0, outputs SHALL be:
- tx_tready=0, rx_tvalid=0, rx_err=0, rx_tdata=0, SPI4wire_MISO=0.
- State IDLE, buffer empty, not armed.
- Synchronizer flops set to CS_N=1, SCK=0, MOSI=0.
REQ-020 Reset asserted mid-frame SHALL abort the frame with no rx_tvalid and no rx_err. After release, the block waits for CS_N to go high, then low, before starting a new frame.
REQ-021 tx_tready SHALL rise on the first clk edge after reset release at which the state is IDLE.

Verification
REQ-022 Mode 0 (cpol=0, cpha=0), adr=8, dat=24, tx word 0xA5C3_0F12 loaded, master sends 0x8012_3456 -> MISO carries 0xA5C30F12 MSB first; rx_tvalid pulses once with rx_tdata=0x80123456.
REQ-023 Mode 3 (cpol=1, cpha=1), adr=16, dat=8, buffer empty, master sends 0x1234AB in 24 bits -> MISO is all 0; rx_tdata=0x001234AB.
REQ-024 Mode 0, adr=8, dat=8, CS_N raised after 12 SCK edges -> rx_err pulses once; rx_tvalid stays 0; rx_tdata unchanged.
REQ-025 tx_tvalid asserted in the same cycle as the CS_N fall, with word 0xDEADBEEF -> the current frame sends 0; the next frame sends 0xDEADBEEF; tx_tready stays 0 until that next frame ends.
REQ-026 rst_n pulsed low after 5 bits of a frame, with CS_N still low -> no output pulses; the frame that follows after CS_N goes high then low is received correctly.
REQ-027 Back-to-back frames with 2 SCK periods of CS_N high between them -> two rx_tvalid pulses with the correct data; the buffer reloads between frames.
